// File: rtl/pla_x1dn_bist.sv
// pla_x1dn_bist: self-test controller for a 27-input / 6-output PLA.
// An LFSR drives the PLA inputs one pattern per cycle and a 16-bit MISR
// compacts the PLA responses; the final signature is compared against a
// golden value once the requested number of patterns has been applied.
//
// Handshake: start is a single-cycle request that is accepted only while
// idle or finished (dbg_state IDLE/DONE) and is dropped while busy; abort
// is a level that only acts while busy. Completion is reported by the
// done level, which stays high (with pass, signature, applied, x_out
// frozen) until the next accepted start or reset.
module pla_x1dn_bist #(
    parameter logic [26:0] SEED      = 27'h0000001,
    parameter logic [15:0] MISR_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] pat_count,
    input  logic [15:0] expected_sig,
    input  logic [5:0]  z_in,
    output logic [26:0] x_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] applied,
    output logic [1:0]  dbg_state
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [26:0] SEED_EFF = (SEED == 27'h0) ? 27'h0000001 : SEED;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [26:0] r_x;
    logic [15:0] r_sig;
    logic [15:0] r_applied;
    logic [15:0] r_count;

    state_t      w_next_state;
    logic [26:0] w_next_x;
    logic [15:0] w_next_sig;
    logic [15:0] w_next_applied;
    logic [15:0] w_next_count;

    logic [26:0] w_lfsr_step;
    logic [15:0] w_misr_step;
    logic [15:0] w_applied_inc;

    // Fibonacci LFSR x^27+x^5+x^2+x+1, shifting toward the MSB.
    assign w_lfsr_step   = {r_x[25:0], r_x[26] ^ r_x[4] ^ r_x[1] ^ r_x[0]};
    // CCITT-polynomial MISR with the six PLA outputs folded into the low bits.
    assign w_misr_step   = ({r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000))
                           ^ {10'b0, z_in};
    // Cannot wrap: the run ends when this reaches the latched count (<= 65535).
    assign w_applied_inc = r_applied + 16'd1;

    // State and datapath registers; asynchronous reset discards any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_x       <= 27'h0;
            r_sig     <= 16'h0000;
            r_applied <= 16'h0000;
            r_count   <= 16'h0000;
        end else begin
            r_state   <= w_next_state;
            r_x       <= w_next_x;
            r_sig     <= w_next_sig;
            r_applied <= w_next_applied;
            r_count   <= w_next_count;
        end
    end

    // Next-state and datapath update; everything holds unless a case acts.
    always_comb begin
        w_next_state   = r_state;
        w_next_x       = r_x;
        w_next_sig     = r_sig;
        w_next_applied = r_applied;
        w_next_count   = r_count;
        case (r_state)
            S_IDLE, S_DONE: begin
                // abort is ignored here, so start wins when both are high.
                if (start) begin
                    w_next_sig     = MISR_INIT;
                    w_next_applied = 16'h0000;
                    w_next_count   = pat_count;
                    if (pat_count != 16'h0000) begin
                        w_next_x     = SEED_EFF;
                        w_next_state = S_RUN;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_RUN: begin
                // start is ignored while running; abort freezes all values.
                if (abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_sig     = w_misr_step;
                    w_next_applied = w_applied_inc;
                    w_next_x       = w_lfsr_step;
                    if (w_applied_inc == r_count) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign x_out     = r_x;
    assign signature = r_sig;
    assign applied   = r_applied;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign pass      = (r_state == S_DONE) && (r_sig == expected_sig);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pla_x1dn_bist.sv
// Bench for pla_x1dn_bist: a modelled PLA answers x_out combinationally,
// stimulus tasks push the expected end-of-run record into exp_q, and an
// independent monitor pops and compares whenever a run finishes or aborts.
module tb_pla_x1dn_bist;

  localparam logic [26:0] SEED      = 27'h0000001;
  localparam logic [15:0] MISR_INIT = 16'h0000;
  localparam logic [26:0] TAPS      = 27'h4000013;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] pat_count;
  logic [15:0] expected_sig;
  logic [5:0]  z_in;
  logic [26:0] x_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] applied;
  logic [1:0]  dbg_state;

  pla_x1dn_bist #(.SEED(SEED), .MISR_INIT(MISR_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pat_count(pat_count), .expected_sig(expected_sig), .z_in(z_in),
    .x_out(x_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .applied(applied), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- PLA model ----------------
  logic [26:0] pla_mask [6];
  logic [5:0]  z_const;

  always_comb begin
    z_in = z_const;
    for (int i = 0; i < 6; i++) z_in[i] = z_const[i] ^ (^(x_out & pla_mask[i]));
  end

  function automatic logic [5:0] pla_resp(input logic [26:0] x);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = z_const[i] ^ (^(x & pla_mask[i]));
    return r;
  endfunction

  // Polynomial arithmetic form of the reference model.
  function automatic logic [26:0] lfsr_step(input logic [26:0] x);
    logic fb;
    logic [26:0] r;
    fb = ^(x & TAPS);
    r  = (x << 1) | {26'b0, fb};
    return r;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] z);
    int t;
    t = int'(s) * 2;
    if (t >= 32'h10000) t = t ^ 32'h11021;
    t = t ^ int'(z);
    return t[15:0];
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        done;
    logic [15:0] sig;
    logic [15:0] applied;
    logic [26:0] x;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  logic [26:0] m_x;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_busy;
  initial begin
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if ((prev_busy && !busy) || (start && !prev_busy && pat_count == 16'h0)) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_end: got an end of run with nothing expected at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("end_done", done, e.done);
            check("end_busy", busy, 1'b0);
            check("end_sig", signature, e.sig);
            check("end_applied", applied, e.applied);
            check("end_x", x_out, e.x);
            check("end_pass", pass, e.pass);
          end
        end
        prev_busy = busy;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_test(input int n, input int abort_at, input bit want_pass,
                          input bit sa_same, input bit start_mid);
    logic [26:0] x;
    logic [15:0] s;
    logic [26:0] xs[$];
    exp_t        e;
    int          steps;
    int          cnt;
    s     = MISR_INIT;
    x     = (n > 0) ? SEED : m_x;
    steps = (abort_at > 0) ? abort_at - 1 : n;
    for (int k = 0; k < steps; k++) begin
      if (k < 8) xs.push_back(x);
      s = misr_step(s, pla_resp(x));
      x = lfsr_step(x);
    end
    m_x       = x;
    e.done    = (abort_at == 0);
    e.sig     = s;
    e.applied = 16'(steps);
    e.x       = x;
    e.pass    = (abort_at == 0) && want_pass;
    exp_q.push_back(e);

    @(negedge clk);
    expected_sig = want_pass ? s : (s ^ (16'h1 << $urandom_range(15, 0)));
    start        = 1'b1;
    abort        = sa_same;
    pat_count    = 16'(n);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", {busy, done}, 2'b00);
    end else begin
      cnt = 0;
      while (!done && cnt < n + 10) begin
        if (busy && cnt < xs.size()) check("run_x", x_out, xs[cnt]);
        if (start_mid && cnt == 1) begin
          start     = 1'b1;
          pat_count = 16'h0;
        end else begin
          start     = 1'b0;
          pat_count = 16'(n);
        end
        @(negedge clk);
        cnt++;
      end
      start = 1'b0;
      check("run_finished", done, 1'b1);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    pat_count    = 16'h0;
    expected_sig = 16'h0;
    z_const      = 6'h0;
    m_x          = 27'h0;
    for (int i = 0; i < 6; i++) pla_mask[i] = 27'h0;

    // Reset values
    #12;
    check("rst_x", x_out, 27'h0);
    check("rst_sig", signature, 16'h0);
    check("rst_applied", applied, 16'h0);
    check("rst_flags", {busy, done, pass}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_release", {busy, done, x_out}, 29'h0);

    // Three patterns with a silent PLA
    run_test(3, 0, 1, 0, 0);
    check("d3_sig", signature, 16'h0000);
    check("d3_applied", applied, 16'd3);

    // One pattern, all outputs high, pass and fail
    z_const = 6'h3F;
    run_test(1, 0, 1, 0, 0);
    check("d1_sig", signature, 16'h003F);
    check("d1_pass", pass, 1'b1);
    expected_sig = 16'h003E;
    #1;
    check("d1_fail", pass, 1'b0);

    // Two patterns with z=1
    z_const = 6'h01;
    run_test(2, 0, 1, 0, 0);
    check("d2_sig", signature, 16'h0003);

    // Abort on 4th RUN cycle, then restart
    run_test(10, 4, 0, 0, 0);
    check("abort_applied", applied, 16'd3);
    run_test(5, 0, 1, 0, 0);

    // Zero-count start: x_out unchanged
    run_test(0, 0, 1, 0, 0);
    check("zero_applied", applied, 16'd0);

    // abort while done is ignored
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    check("abort_in_done", {busy, done}, 2'b01);
    check("abort_in_done_applied", applied, 16'd0);

    // start+abort together from DONE: start wins; start while running ignored
    run_test(6, 0, 1, 1, 1);

    // Randomised runs against a random PLA
    for (int r = 0; r < 24; r++) begin
      int n;
      int ab;
      for (int i = 0; i < 6; i++) pla_mask[i] = 27'($urandom);
      z_const = 6'($urandom);
      n  = $urandom_range(40, 0);
      ab = (n > 0 && $urandom_range(3, 0) == 0) ? $urandom_range(n, 1) : 0;
      run_test(n, ab, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               (n >= 3 && ab == 0) ? 1'($urandom_range(1, 0)) : 1'b0);
    end

    // Maximum count terminates at 16'hFFFF
    run_test(65535, 0, 1, 0, 0);
    check("max_applied", applied, 16'hFFFF);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start     = 1'b1;
    pat_count = 16'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", x_out, 27'h0);
    check("mid_rst_sig", signature, 16'h0);
    check("mid_rst_applied", applied, 16'h0);
    check("mid_rst_flags", {busy, done, pass}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    m_x   = 27'h0;
    repeat (5) @(negedge clk);
    check("stay_idle", {busy, done, x_out}, 29'h0);

    // Every queued expectation must have been consumed
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
